// File: rtl/cpu_datapath.sv
// cpu_datapath: 32-bit single-bus datapath of a microprogrammed RISC CPU.
// Latency: every register loads on the rising Clock edge after its strobe; all outputs are combinational.
// Backpressure: none; the external control unit issues one micro-step per clock and is never stalled.
//
// Ports:
//   Clock, Clear            rising-edge clock, synchronous active-high clear (memory is kept)
//   Read, Write             memory -> MDR, MDR -> memory (address MAR[8:0])
//   *in strobes             register load enables (HI, LO, PC, IR, Y, Z, MAR, MDR, ports, CON)
//   *out strobes            bus drive selects; Gra/Grb/Grc pick the IR register field
//   BAout, Rout, Rin        register-file drive (R0 reads as 0), drive, load
//   IncPC                   ALU computes bus+1 instead of the IR opcode
//   Busout, Zlow_out,       bus value, Z halves, R1/R0 contents, branch condition flip-flop
//   Zhi_out, R1_out, R0_out, CON_out
module cpu_datapath #(
    parameter int          MEM_DEPTH   = 512,
    parameter string       MEM_INIT    = "",
    parameter logic [31:0] INPORT_DATA = 32'h0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Read,
    input  logic        Write,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Out_Portin,
    input  logic        In_Portin,
    input  logic        IncPC,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhiout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Cout,
    input  logic        InPortout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        BAout,
    input  logic        Rout,
    input  logic        Rin,
    input  logic        CONin,
    output logic [31:0] Busout,
    output logic [31:0] Zlow_out,
    output logic [31:0] Zhi_out,
    output logic [31:0] R1_out,
    output logic [31:0] R0_out,
    output logic        CON_out
);

    localparam int AW = $clog2(MEM_DEPTH);

    // ALU opcodes (IR[31:27]); load/store/branch/jump forms reuse the adder
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10101;

    // Architectural state
    logic [31:0]   pc_q, ir_q, mdr_q, y_q, hi_q, lo_q;
    logic [AW-1:0] mar_q;   // only the word-address bits of MAR are ever observable
    logic [63:0]   z_q;
    logic [31:0]   inport_q, outport_q;
    logic          con_q;
    logic [31:0]   rf_q [16];
    logic [31:0]   mem_q [MEM_DEPTH];

    // Next-state / combinational values
    logic [31:0] bus;
    logic [3:0]  rf_idx;
    logic [31:0] c_sext;
    logic [31:0] mem_rd;
    logic [31:0] mdr_d;
    logic [63:0] z_d;
    logic [63:0] alu_res;
    logic        con_d;

    // Memory starts all zero at time zero.
    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] = '0;
    end

    // Register-file index from the IR field chosen by the Gr* strobes
    always_comb begin
        rf_idx = 4'd0;
        if (Gra)      rf_idx = ir_q[26:23];
        else if (Grb) rf_idx = ir_q[22:19];
        else if (Grc) rf_idx = ir_q[18:15];
    end

    assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
    assign mem_rd = mem_q[mar_q];

    // Bus multiplexer, highest priority first; nothing selected drives zero
    always_comb begin
        bus = '0;
        if (Rout)           bus = rf_q[rf_idx];
        else if (BAout)     bus = (rf_idx == 4'd0) ? 32'd0 : rf_q[rf_idx];
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhiout)    bus = z_q[63:32];
        else if (Zlowout)   bus = z_q[31:0];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inport_q;
        else if (Cout)      bus = c_sext;
    end

    // ALU: A = Y, B = bus
    always_comb begin
        logic [31:0]        a, b;
        logic [4:0]         sh;
        logic [5:0]         rsh;
        logic signed [63:0] prod;
        logic signed [31:0] quo, rem;
        a    = y_q;
        b    = bus;
        sh   = b[4:0];
        rsh  = 6'd32 - {1'b0, sh};
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        quo  = '0;
        rem  = '0;
        if (b != 32'd0) begin
            quo = $signed(a) / $signed(b);
            rem = $signed(a) % $signed(b);
        end
        alu_res = {32'd0, b};
        case (ir_q[31:27])
            OP_LD, OP_LDI, OP_ST, OP_ADD,
            OP_ADDI, OP_BR, OP_JAL:  alu_res = {32'd0, a + b};
            OP_SUB:                  alu_res = {32'd0, a - b};
            OP_AND, OP_ANDI:         alu_res = {32'd0, a & b};
            OP_OR, OP_ORI:           alu_res = {32'd0, a | b};
            OP_SHR:                  alu_res = {32'd0, a >> sh};
            OP_SHRA:                 alu_res = {32'd0, $signed(a) >>> sh};
            OP_SHL:                  alu_res = {32'd0, a << sh};
            // a shift by 32 inside a 32-bit expression yields 0, so sh == 0 falls out correctly
            OP_ROR:                  alu_res = {32'd0, (a >> sh) | (a << rsh)};
            OP_ROL:                  alu_res = {32'd0, (a << sh) | (a >> rsh)};
            OP_MUL:                  alu_res = prod;
            OP_DIV:                  alu_res = {rem, quo};
            OP_NEG:                  alu_res = {32'd0, 32'd0 - b};
            OP_NOT:                  alu_res = {32'd0, ~b};
            default:                 alu_res = {32'd0, b};
        endcase
    end

    assign z_d   = IncPC ? {32'd0, bus + 32'd1} : alu_res;
    assign mdr_d = Read ? mem_rd : bus;

    // Branch condition from IR[20:19] evaluated on the bus value
    always_comb begin
        con_d = 1'b0;
        case (ir_q[20:19])
            2'b00: con_d = (bus == 32'd0);
            2'b01: con_d = (bus != 32'd0);
            2'b10: con_d = ~bus[31];
            2'b11: con_d = bus[31];
            default: con_d = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            z_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            if (PCin)       pc_q      <= bus;
            if (IRin)       ir_q      <= bus;
            if (MARin)      mar_q     <= bus[AW-1:0];
            if (MDRin)      mdr_q     <= mdr_d;
            if (Yin)        y_q       <= bus;
            if (Zin)        z_q       <= z_d;
            if (HIin)       hi_q      <= bus;
            if (LOin)       lo_q      <= bus;
            if (In_Portin)  inport_q  <= INPORT_DATA;
            if (Out_Portin) outport_q <= bus;
            if (CONin)      con_q     <= con_d;
            if (Rin)        rf_q[rf_idx] <= bus;
        end
    end

    // Memory write uses the pre-edge MDR, so Read+Write returns the old word to MDR
    always @(posedge Clock) begin
        if (Write) mem_q[mar_q] <= mdr_q;
    end

    assign Busout   = bus;
    assign Zlow_out = z_q[31:0];
    assign Zhi_out  = z_q[63:32];
    assign R1_out   = rf_q[1];
    assign R0_out   = rf_q[0];
    assign CON_out  = con_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed micro-step sequences plus randomized ALU/condition
// operands for cpu_datapath, checked against a behavioural arithmetic model.
// Operand values reach the bus by building them in Z with doubling and +1 steps.
module tb_cpu_datapath;

  localparam logic [31:0] INPORT = 32'hA5C3_0F1E;

  logic Clock = 1'b0;
  logic Clear, Read, Write, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin;
  logic Out_Portin, In_Portin, IncPC, HIout, LOout, Zhiout, Zlowout, PCout;
  logic MDRout, Cout, InPortout, Gra, Grb, Grc, BAout, Rout, Rin, CONin;
  logic [31:0] Busout, Zlow_out, Zhi_out, R1_out, R0_out;
  logic        CON_out;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  cpu_datapath #(.MEM_DEPTH(512), .MEM_INIT(""), .INPORT_DATA(INPORT)) dut (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin), .Out_Portin(Out_Portin), .In_Portin(In_Portin),
    .IncPC(IncPC), .HIout(HIout), .LOout(LOout), .Zhiout(Zhiout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .Cout(Cout), .InPortout(InPortout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout), .Rout(Rout), .Rin(Rin),
    .CONin(CONin), .Busout(Busout), .Zlow_out(Zlow_out), .Zhi_out(Zhi_out),
    .R1_out(R1_out), .R0_out(R0_out), .CON_out(CON_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {Clear, Read, Write, HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin} = '0;
    {Out_Portin, In_Portin, IncPC, HIout, LOout, Zhiout, Zlowout, PCout} = '0;
    {MDRout, Cout, InPortout, Gra, Grb, Grc, BAout, Rout, Rin, CONin} = '0;
  endtask

  // One micro-step: strobes set by the caller are applied over one rising edge
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  // Leaves IR=0 (add opcode), then builds v in Z by doubling (Y=Z; Z=Y+Z) and +1 steps
  task automatic load_z(input logic [31:0] v);
    bit started = 0;
    IRin = 1; Yin = 1; tick();
    Zin = 1; tick();
    for (int i = 31; i >= 0; i--) begin
      if (started) begin
        Zlowout = 1; Yin = 1; tick();
        Zlowout = 1; Zin = 1; tick();
      end
      if (v[i]) begin
        Zlowout = 1; IncPC = 1; Zin = 1; tick();
        started = 1;
      end
    end
  endtask

  task automatic put_mdr(input logic [31:0] v);
    load_z(v);
    Zlowout = 1; MDRin = 1; tick();
  endtask

  task automatic set_ir(input logic [31:0] v);
    load_z(v);
    Zlowout = 1; IRin = 1; tick();
  endtask

  // Store a word at mem[0], clear, fetch it, then run the branch-target micro-steps
  task automatic run_branch(input logic [31:0] word, input bit exp_con, input bit take);
    put_mdr(word);
    MARin = 1; tick();
    Write = 1; tick();
    Clear = 1; tick();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; tick();
    MDRout = 1; IRin = 1; #1;
    chk("fetch_mdr", Busout, word);
    tick();
    PCout = 1; #1;
    chk("fetch_pc", Busout, 32'd1);
    idle();
    Gra = 1; Rout = 1; CONin = 1; tick();
    chk("branch_con", CON_out, exp_con);
    PCout = 1; Yin = 1; tick();
    Cout = 1; Zin = 1; tick();
    chk("branch_target_z", Zlow_out, 32'd6);
    if (take) begin
      Zlowout = 1; PCin = 1; tick();
    end
    PCout = 1; #1;
    chk("branch_pc", Busout, take ? 32'd6 : 32'd1);
    idle();
  endtask

  // Y=a (via HI), bus=b (via LO), opcode in IR, result into Z
  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_z(a);
    Zlowout = 1; HIin = 1; tick();
    load_z(b);
    Zlowout = 1; LOin = 1; tick();
    set_ir({op, 27'($urandom)});
    HIout = 1; Yin = 1; tick();
    LOout = 1; Zin = 1; tick();
  endtask

  // Reference ALU written from the instruction-set definition
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned n;
    longint sa, sb;
    logic [63:0] aa;
    n  = b[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    aa = {a, a};
    case (op)
      0, 1, 2, 3, 12, 19, 21: return {32'd0, 32'(64'(a) + 64'(b))};
      4:      return {32'd0, 32'(sa - sb)};
      5, 13:  return {32'd0, a & b};
      6, 14:  return {32'd0, a | b};
      7:      return {32'd0, 32'(64'(a) / (64'd1 << n))};
      8:      return {32'd0, 32'(sa >>> n)};
      9:      return {32'd0, 32'(64'(a) * (64'd1 << n))};
      10:     return {32'd0, 32'(aa >> n)};
      11:     return {32'd0, 32'(aa >> (32 - n))};
      15:     return 64'(sa * sb);
      16:     return (sb == 0) ? 64'd0 : {32'(sa % sb), 32'(sa / sb)};
      17:     return {32'd0, 32'(-sb)};
      18:     return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  function automatic bit con_ref(input logic [1:0] c, input logic [31:0] v);
    case (c)
      2'b00:   return v == 0;
      2'b01:   return v != 0;
      2'b10:   return $signed(v) >= 0;
      default: return $signed(v) < 0;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, v;
    logic [1:0]  c;
    idle();

    // Reset state
    Clear = 1; tick();
    chk("rst_bus", Busout, 32'd0);
    chk("rst_zlow", Zlow_out, 32'd0);
    chk("rst_zhi", Zhi_out, 32'd0);
    chk("rst_r0", R0_out, 32'd0);
    chk("rst_r1", R1_out, 32'd0);
    chk("rst_con", CON_out, 1'b0);
    PCout = 1; #1;
    chk("rst_pc", Busout, 32'd0);
    idle();

    // brzr R1,5 taken; brnz R1,5 not taken with PC load withheld
    run_branch(32'h9880_0005, 1'b1, 1'b1);
    run_branch(32'h9888_0005, 1'b0, 1'b0);

    // Register file: R1 and R0 loads, BAout/Rout on index 0 and 1
    put_mdr(32'h12);
    set_ir(32'h0080_0000);
    MDRout = 1; Gra = 1; Rin = 1; tick();
    chk("r1_load", R1_out, 32'h12);
    Gra = 1; BAout = 1; #1;
    chk("baout_r1", Busout, 32'h12);
    idle();
    put_mdr(32'h34);
    set_ir(32'h0);
    MDRout = 1; Gra = 1; Rin = 1; tick();
    chk("r0_load", R0_out, 32'h34);
    Gra = 1; BAout = 1; #1;
    chk("baout_r0_zero", Busout, 32'd0);
    idle();
    Gra = 1; Rout = 1; #1;
    chk("rout_r0", Busout, 32'h34);
    idle();

    // mul and div directed cases
    alu_run(5'b01111, 32'hFFFF_FFFD, 32'd7);
    chk("mul_hi", Zhi_out, 32'hFFFF_FFFF);
    chk("mul_lo", Zlow_out, 32'hFFFF_FFEB);
    HIout = 1; #1;
    chk("hi_reg", Busout, 32'hFFFF_FFFD);
    idle();
    alu_run(5'b10000, 32'd17, 32'd5);
    chk("div_q", Zlow_out, 32'd3);
    chk("div_r", Zhi_out, 32'd2);
    alu_run(5'b10000, 32'd17, 32'd0);
    chk("div0", {Zhi_out, Zlow_out}, 64'd0);

    // Memory write/read at MAR=0x20, then simultaneous Read+Write
    load_z(32'h20);
    Zlowout = 1; MARin = 1; tick();
    put_mdr(32'hCAFE_BABE);
    Write = 1; tick();
    MDRin = 1; tick();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; #1;
    chk("mem_rd", Busout, 32'hCAFE_BABE);
    idle();
    put_mdr(32'h11);
    Read = 1; Write = 1; MDRin = 1; tick();
    MDRout = 1; #1;
    chk("rw_old", Busout, 32'hCAFE_BABE);
    idle();
    Read = 1; MDRin = 1; tick();
    MDRout = 1; #1;
    chk("rw_new", Busout, 32'h11);
    idle();

    // In-port capture and bus priority
    In_Portin = 1; tick();
    InPortout = 1; #1;
    chk("inport", Busout, INPORT);
    idle();
    load_z(32'h55);
    Zlowout = 1; PCin = 1; tick();
    Zlowout = 1; IncPC = 1; Zin = 1; tick();
    Zlowout = 1; PCout = 1; InPortout = 1; #1;
    chk("prio_z_over_pc", Busout, 32'h56);
    idle();
    PCout = 1; Cout = 1; #1;
    chk("prio_pc_over_c", Busout, 32'h55);
    idle();

    // Clear overrides enables
    set_ir(32'h0);
    CONin = 1; tick();
    chk("con_set", CON_out, 1'b1);
    load_z(32'h77);
    Clear = 1; Zin = 1; PCin = 1; Zlowout = 1; Rin = 1; tick();
    chk("clr_zlow", Zlow_out, 32'd0);
    chk("clr_zhi", Zhi_out, 32'd0);
    chk("clr_con", CON_out, 1'b0);
    chk("clr_r0", R0_out, 32'd0);
    chk("clr_r1", R1_out, 32'd0);
    PCout = 1; #1;
    chk("clr_pc", Busout, 32'd0);
    idle();

    // Random branch conditions
    for (int i = 0; i < 8; i++) begin
      v = (i % 3 == 0) ? 32'd0 : $urandom;
      c = 2'(i);
      load_z(v);
      Zlowout = 1; HIin = 1; tick();
      set_ir({12'h000, 1'b0, c, 19'h0});
      HIout = 1; CONin = 1; tick();
      chk("rand_con", CON_out, con_ref(c, v));
    end

    // Random operands through every opcode
    for (int op = 0; op < 32; op++) begin
      a = $urandom;
      b = $urandom;
      if (op == 16 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      alu_run(5'(op), a, b);
      chk("rand_alu_lo", Zlow_out, alu_ref(5'(op), a, b) & 64'hFFFF_FFFF);
      chk("rand_alu_hi", Zhi_out, alu_ref(5'(op), a, b) >> 32);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
